// File: rtl/csr_cmd_master.sv
// -----------------------------------------------------------------------------
// csr_cmd_master
//
// CSR bus master. Accepts read/write commands on a valid/ready stream, queues
// them in a small FIFO, and turns each into a single-cycle access on a
// strobe-per-register CSR bus. Read data (and, optionally, write readback) is
// returned on a valid/ready response stream.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge. The consumer may change ready freely.
//
// Build option:
//   CSR_CMD_MASTER_WR_ECHO_EN  when defined, writes also wait READ_LATENCY and
//                              return a response carrying the register
//                              readback. When undefined, writes return nothing.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_rw               1 = write, 0 = read
//   cmd_sel              register select
//   cmd_data             write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             sampled register data (0 on select error)
//   rsp_sel              select of the originating command
//   rsp_err              select was out of range
//   csr_data_o           write data bus (holds last written value)
//   csr_stb_o            one-hot write strobes
//   csr_data_i           flattened readback, register i at [(i+1)*W-1 : i*W]
//   csr_rw               type of the access in progress
//   csr_in_progress      access (ACCESS or WAIT) active
//   ready                post-reset hold-off has elapsed
//   err_count            saturating count of out-of-range commands
//   dbg_state_o          current FSM state (debug)
// -----------------------------------------------------------------------------
module csr_cmd_master #(
  parameter int CSR_DATA_BUS_WIDTH   = 32,
  parameter int CSR_STROBE_BUS_WIDTH = 32,
  parameter int CMD_FIFO_DEPTH       = 4,
  parameter int READ_LATENCY         = 1,
  parameter int CSR_RESET_DELAY      = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cmd_valid,
  output logic                                                 cmd_ready,
  input  logic                                                 cmd_rw,
  input  logic [$clog2(CSR_STROBE_BUS_WIDTH)-1:0]              cmd_sel,
  input  logic [CSR_DATA_BUS_WIDTH-1:0]                        cmd_data,
  output logic                                                 rsp_valid,
  input  logic                                                 rsp_ready,
  output logic [CSR_DATA_BUS_WIDTH-1:0]                        rsp_data,
  output logic [$clog2(CSR_STROBE_BUS_WIDTH)-1:0]              rsp_sel,
  output logic                                                 rsp_err,
  output logic [CSR_DATA_BUS_WIDTH-1:0]                        csr_data_o,
  output logic [CSR_STROBE_BUS_WIDTH-1:0]                      csr_stb_o,
  input  logic [CSR_DATA_BUS_WIDTH*CSR_STROBE_BUS_WIDTH-1:0]   csr_data_i,
  output logic                                                 csr_rw,
  output logic                                                 csr_in_progress,
  output logic                                                 ready,
  output logic [7:0]                                           err_count,
  output logic [2:0]                                           dbg_state_o
);

  localparam int W       = CSR_DATA_BUS_WIDTH;
  localparam int N       = CSR_STROBE_BUS_WIDTH;
  localparam int SW      = $clog2(CSR_STROBE_BUS_WIDTH);
  localparam int AW      = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_MAX = (CSR_RESET_DELAY > READ_LATENCY) ? CSR_RESET_DELAY : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef CSR_CMD_MASTER_WR_ECHO_EN
  localparam bit WR_ECHO = 1'b1;
`else
  localparam bit WR_ECHO = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // hold-off count in INIT, remaining WAIT cycles

  logic             cur_rw_q, cur_rw_d;    // command currently on the bus
  logic [SW-1:0]    cur_sel_q, cur_sel_d;
  logic             cur_err_q, cur_err_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [SW-1:0]    rsp_sel_q, rsp_sel_d;
  logic             rsp_err_q, rsp_err_d;
  logic [W-1:0]     csr_data_q, csr_data_d;
  logic [N-1:0]     csr_stb_q, csr_stb_d;
  logic             csr_rw_q, csr_rw_d;
  logic             in_prog_q, in_prog_d;
  logic             ready_q, ready_d;
  logic [7:0]       err_count_q, err_count_d;

  // ---------------------------------------------------------------------------
  // Command FIFO (pointers carry one extra wrap bit)
  // ---------------------------------------------------------------------------
  logic          fifo_rw   [CMD_FIFO_DEPTH];
  logic [SW-1:0] fifo_sel  [CMD_FIFO_DEPTH];
  logic [W-1:0]  fifo_data [CMD_FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_count;
  logic [AW:0]   fifo_count_next;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic          head_rw;
  logic [SW-1:0] head_sel;
  logic [W-1:0]  head_data;
  logic          head_err;
  logic          needs_rsp;
  logic [W-1:0]  rd_word;

  // cmd_ready is registered and reflects the exact current fill level, so a
  // push is never accepted while the FIFO is full.
  assign push       = cmd_valid && cmd_ready_q;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);

  assign head_rw   = fifo_rw[rd_ptr_q[AW-1:0]];
  assign head_sel  = fifo_sel[rd_ptr_q[AW-1:0]];
  assign head_data = fifo_data[rd_ptr_q[AW-1:0]];
  assign head_err  = (int'(head_sel) >= N);

  // Whether the command on the bus returns a response.
  assign needs_rsp = !cur_rw_q || WR_ECHO;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr_q[AW-1:0]]   <= cmd_rw;
      fifo_sel[wr_ptr_q[AW-1:0]]  <= cmd_sel;
      fifo_data[wr_ptr_q[AW-1:0]] <= cmd_data;
    end
  end

  // Readback mux for the register being accessed.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(cur_sel_q) == i) rd_word = csr_data_i[i*W +: W];
    end
  end

  // ---------------------------------------------------------------------------
  // State register (plus all datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      cur_rw_q    <= 1'b0;
      cur_sel_q   <= '0;
      cur_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      rsp_err_q   <= 1'b0;
      csr_data_q  <= '0;
      csr_stb_q   <= '0;
      csr_rw_q    <= 1'b0;
      in_prog_q   <= 1'b0;
      ready_q     <= 1'b0;
      err_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_rw_q    <= cur_rw_d;
      cur_sel_q   <= cur_sel_d;
      cur_err_q   <= cur_err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_err_q   <= rsp_err_d;
      csr_data_q  <= csr_data_d;
      csr_stb_q   <= csr_stb_d;
      csr_rw_q    <= csr_rw_d;
      in_prog_q   <= in_prog_d;
      ready_q     <= ready_d;
      err_count_q <= err_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(CSR_RESET_DELAY - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (needs_rsp) begin
          state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
        end else if (!fifo_empty) begin
          // Plain writes chain straight into the next access.
          pop     = 1'b1;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = '0;
    cur_rw_d    = cur_rw_q;
    cur_sel_d   = cur_sel_q;
    cur_err_d   = cur_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_err_d   = rsp_err_q;
    csr_data_d  = csr_data_q;
    csr_stb_d   = '0;
    csr_rw_d    = 1'b0;
    in_prog_d   = 1'b0;
    err_count_d = err_count_q;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);

    // INIT is only ever entered through reset, so ready is simply "not INIT".
    ready_d = (state_d != S_INIT);

    fifo_count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    cmd_ready_d     = ready_d && (fifo_count_next != (AW+1)'(CMD_FIFO_DEPTH));

    // Hold-off and wait counters.
    if (state_q == S_INIT && state_d == S_INIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == S_ACCESS && state_d == S_WAIT) begin
      cnt_d = CNT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);
    end else if (state_q == S_WAIT && state_d == S_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Starting an access: latch the command and drive the bus for one cycle.
    if (pop) begin
      cur_rw_d  = head_rw;
      cur_sel_d = head_sel;
      cur_err_d = head_err;
      in_prog_d = 1'b1;
      csr_rw_d  = head_rw;
      if (head_err) begin
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end else if (head_rw) begin
        csr_data_d = head_data;
        for (int i = 0; i < N; i++) begin
          csr_stb_d[i] = (int'(head_sel) == i);
        end
      end
    end

    // Latency wait keeps the access marked active.
    if (state_d == S_WAIT) begin
      in_prog_d = 1'b1;
      csr_rw_d  = cur_rw_q;
    end

    // Response retires on the handshake edge.
    if (state_q == S_RESP && rsp_ready) rsp_valid_d = 1'b0;

    // Sample readback on the edge that enters RESP.
    if ((state_q == S_ACCESS || state_q == S_WAIT) && state_d == S_RESP) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cur_err_q ? '0 : rd_word;
      rsp_sel_d   = cur_sel_q;
      rsp_err_d   = cur_err_q;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_sel         = rsp_sel_q;
  assign rsp_err         = rsp_err_q;
  assign csr_data_o      = csr_data_q;
  assign csr_stb_o       = csr_stb_q;
  assign csr_rw          = csr_rw_q;
  assign csr_in_progress = in_prog_q;
  assign ready           = ready_q;
  assign err_count       = err_count_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_csr_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_csr_cmd_master
//
// Directed bench for csr_cmd_master with 20 registers, read latency 3, FIFO
// depth 4 and a reset hold-off of 4 cycles. Register i reads back
// 0xA000_0000 + i, except register 5 which reads 0x12345678.
// -----------------------------------------------------------------------------
module tb_csr_cmd_master;

  localparam int W     = 32;
  localparam int N     = 20;
  localparam int SW    = 5;
  localparam int DEPTH = 4;
  localparam int RL    = 3;
  localparam int DELAY = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_rw;
  logic [SW-1:0]   cmd_sel;
  logic [W-1:0]    cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [SW-1:0]   rsp_sel;
  logic            rsp_err;
  logic [W-1:0]    csr_data_o;
  logic [N-1:0]    csr_stb_o;
  logic [W*N-1:0]  csr_data_i;
  logic            csr_rw;
  logic            csr_in_progress;
  logic            ready;
  logic [7:0]      err_count;
  logic [2:0]      dbg_state;

  logic [W-1:0]    regs [N];

  always_comb begin
    for (int i = 0; i < N; i++) csr_data_i[i*W +: W] = regs[i];
  end

  csr_cmd_master #(
    .CSR_DATA_BUS_WIDTH   (W),
    .CSR_STROBE_BUS_WIDTH (N),
    .CMD_FIFO_DEPTH       (DEPTH),
    .READ_LATENCY         (RL),
    .CSR_RESET_DELAY      (DELAY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_rw          (cmd_rw),
    .cmd_sel         (cmd_sel),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_sel         (rsp_sel),
    .rsp_err         (rsp_err),
    .csr_data_o      (csr_data_o),
    .csr_stb_o       (csr_stb_o),
    .csr_data_i      (csr_data_i),
    .csr_rw          (csr_rw),
    .csr_in_progress (csr_in_progress),
    .ready           (ready),
    .err_count       (err_count),
    .dbg_state_o     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge on which the command was accepted.
  task automatic push_cmd(input logic rw, input logic [SW-1:0] sel, input logic [W-1:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_sel   = sel;
    cmd_data  = data;
    while (!cmd_ready && n < 64) begin
      step();
      n++;
    end
    if (n == 64) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 32) begin
      step();
      n++;
    end
    check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp(input logic [SW-1:0] exp_sel, input logic exp_err);
    logic [W-1:0] exp_data;
    rsp_ready = 1'b1;
    wait_rsp_valid();
    exp_data = exp_q.pop_front();
    check("rsp_data", rsp_data, exp_data);
    check("rsp_sel", {27'd0, rsp_sel}, {27'd0, exp_sel});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] one;
    logic        seen;
    int          n;
    one = 32'd1;

    for (int i = 0; i < N; i++) regs[i] = 32'hA000_0000 + i;
    regs[5] = 32'h1234_5678;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_sel   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_stb", csr_stb_o, 32'd0);
    check("rst_in_prog", {31'd0, csr_in_progress}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_data_o", csr_data_o, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Hold-off: ready and cmd_ready rise on the 4th edge after release
    rst = 1'b0;
    for (int e = 1; e <= DELAY; e++) begin
      step();
      check($sformatf("holdoff_ready_%0d", e), {31'd0, ready}, (e == DELAY) ? 32'd1 : 32'd0);
      check($sformatf("holdoff_cmd_ready_%0d", e), {31'd0, cmd_ready}, (e == DELAY) ? 32'd1 : 32'd0);
    end

    // Single write sel=3
    push_cmd(1'b1, 5'd3, 32'hDEAD_BEEF);
    check("wr_stb_before", csr_stb_o, 32'd0);
    step();
    check("wr_stb", csr_stb_o, 32'h8);
    check("wr_data_o", csr_data_o, 32'hDEAD_BEEF);
    check("wr_rw", {31'd0, csr_rw}, 32'd1);
    check("wr_in_prog", {31'd0, csr_in_progress}, 32'd1);
    step();
    check("wr_stb_after", csr_stb_o, 32'd0);
    check("wr_in_prog_after", {31'd0, csr_in_progress}, 32'd0);
    check("wr_data_hold", csr_data_o, 32'hDEAD_BEEF);
    repeat (3) step();
    check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Read sel=5 with latency 3: rsp_valid at edge k+4
    exp_q.push_back(32'h1234_5678);
    push_cmd(1'b0, 5'd5, 32'd0);
    step();
    check("rd_in_prog_k1", {31'd0, csr_in_progress}, 32'd1);
    check("rd_rw_k1", {31'd0, csr_rw}, 32'd0);
    check("rd_no_stb", csr_stb_o, 32'd0);
    step();
    step();
    check("rd_in_prog_k3", {31'd0, csr_in_progress}, 32'd1);
    check("rd_rsp_valid_k3", {31'd0, rsp_valid}, 32'd0);
    step();
    check("rd_rsp_valid_k4", {31'd0, rsp_valid}, 32'd1);
    check("rd_in_prog_k4", {31'd0, csr_in_progress}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rd_hold_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("rd_hold_data_%0d", c), rsp_data, 32'h1234_5678);
    end
    take_rsp(5'd5, 1'b0);

    // FIFO fill behind a stalled read response, then back-to-back writes
    exp_q.push_back(32'hA000_0007);
    push_cmd(1'b0, 5'd7, 32'd0);
    wait_rsp_valid();
    for (int i = 0; i < DEPTH; i++) begin
      push_cmd(1'b1, SW'(i), 32'h100 + i);
      check($sformatf("fill_cmd_ready_%0d", i), {31'd0, cmd_ready}, (i < DEPTH - 1) ? 32'd1 : 32'd0);
    end
    check("fill_no_stb", csr_stb_o, 32'd0);
    take_rsp(5'd7, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("b2b_stb_%0d", i), csr_stb_o, one << i);
      check($sformatf("b2b_data_%0d", i), csr_data_o, 32'h100 + i);
    end
    step();
    check("b2b_stb_end", csr_stb_o, 32'd0);
    check("b2b_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Out-of-range read sel=25
    exp_q.push_back(32'd0);
    push_cmd(1'b0, 5'd25, 32'd0);
    step();
    check("oor_no_stb", csr_stb_o, 32'd0);
    check("oor_in_prog", {31'd0, csr_in_progress}, 32'd1);
    check("oor_err_count", {24'd0, err_count}, 32'd1);
    take_rsp(5'd25, 1'b1);

    // err_count saturation via out-of-range writes
    for (int i = 0; i < 253; i++) push_cmd(1'b1, 5'd25, i);
    repeat (3) step();
    check("err_count_254", {24'd0, err_count}, 32'd254);
    check("oor_wr_no_stb", csr_stb_o, 32'd0);
    push_cmd(1'b1, 5'd25, 32'd0);
    repeat (3) step();
    check("err_count_255", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 45; i++) push_cmd(1'b1, 5'd31, i);
    repeat (3) step();
    check("err_count_sat", {24'd0, err_count}, 32'd255);
    check("oor_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset during RESP with two commands queued
    push_cmd(1'b0, 5'd1, 32'd0);
    wait_rsp_valid();
    push_cmd(1'b1, 5'd2, 32'h55);
    push_cmd(1'b1, 5'd3, 32'h66);
    rst = 1'b1;
    step();
    check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rr_ready", {31'd0, ready}, 32'd0);
    check("rr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rr_err_count", {24'd0, err_count}, 32'd0);
    check("rr_data_o", csr_data_o, 32'd0);
    check("rr_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 10) begin
      step();
      n++;
    end
    check("rr_ready_back", {31'd0, ready}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (csr_stb_o != '0 || csr_in_progress) seen = 1'b1;
    end
    check("rr_no_stale_access", {31'd0, seen}, 32'd0);

    // Highest in-range select after reset
    push_cmd(1'b1, 5'd19, 32'hCAFE_F00D);
    step();
    check("max_sel_stb", csr_stb_o, one << 19);
    check("max_sel_data", csr_data_o, 32'hCAFE_F00D);
    exp_q.push_back(32'hA000_0013);
    push_cmd(1'b0, 5'd19, 32'd0);
    take_rsp(5'd19, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_cmd_master.md
# csr_cmd_master

Synthesizable, parametrised CSR bus master that turns a valid/ready command stream (read/write, select, data) into single-cycle accesses on the strobe-per-register CSR bus and returns read data on a valid/ready response stream. A command FIFO decouples the issuer (soft CPU bridge, sequencer, or bench driver) from the bus. The block owns the post-reset hold-off and the `csr_rw`/`csr_in_progress` status outputs. It generalises the behavioural CSR test master to hardware, adding configurable read latency, command queueing and select range checking.

## Interface
- `CSR_DATA_BUS_WIDTH`, 32, data width per register
- `CSR_STROBE_BUS_WIDTH`, 32, number of registers/strobes; need not be a power of 2; select width `SW = $clog2(CSR_STROBE_BUS_WIDTH)` (localparam)
- `CMD_FIFO_DEPTH`, 4, command FIFO entries; power of 2, ≥2
- `READ_LATENCY`, 1, cycles from access start to read-data sample; 1..15
- `CSR_RESET_DELAY`, 4, cycles after reset release before `ready` rises; ≥1

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake
- `cmd_rw`  in  1  1 = write, 0 = read
- `cmd_sel`  in  SW  register select
- `cmd_data`  in  CSR_DATA_BUS_WIDTH  write data
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake
- `rsp_data`  out  CSR_DATA_BUS_WIDTH  sampled register data
- `rsp_sel`  out  SW  select of the originating command
- `rsp_err`  out  1  select out of range
- `csr_data_o`  out  CSR_DATA_BUS_WIDTH  write data bus
- `csr_stb_o`  out  CSR_STROBE_BUS_WIDTH  one-hot write strobes
- `csr_data_i`  in  CSR_DATA_BUS_WIDTH*CSR_STROBE_BUS_WIDTH  flattened readback; register i at bits [(i+1)*W-1 : i*W]
- `csr_rw`, `csr_in_progress`  out  1  current access type / access active
- `ready`  out  1  hold-off elapsed
- `err_count`  out  8  saturating count of out-of-range commands

## Operation
- All outputs are registered; reset value 0 for every output; FIFO emptied; FSM → INIT.
- FSM: INIT → IDLE → ACCESS → (WAIT) → RESP → IDLE.
  - INIT: count `CSR_RESET_DELAY` edges, then `ready`←1 and go to IDLE. `cmd_ready`=0 throughout INIT.
  - IDLE: when FIFO non-empty, pop a command and go to ACCESS.
  - ACCESS: one cycle. `csr_in_progress`=1 and `csr_rw`=cmd_rw.
    - Write: `csr_stb_o[sel]`=1 and `csr_data_o`=data.
    - Read: no strobe.
    - If `READ_LATENCY`=1, sample `csr_data_i` at the end of ACCESS; otherwise go to WAIT for `READ_LATENCY`-1 cycles, with `csr_in_progress` held at 1.
  - RESP: hold `rsp_*` stable until `rsp_ready`; leave on the handshake edge.
- Writes generate no response; after ACCESS go to IDLE, or directly to ACCESS again if the FIFO is non-empty. Back-to-back writes therefore issue one per cycle.
- `csr_stb_o` is all-zero outside a write ACCESS. `csr_data_o` holds its last written value.
- Out-of-range select (sel ≥ `CSR_STROBE_BUS_WIDTH`):
  - No strobe; `err_count` increments, saturating at 255.
  - Read: response with `rsp_err`=1 and `rsp_data`=0.
  - Write: no response.
- `cmd_ready` = `ready` && FIFO not full. A push is never accepted when full, even on a simultaneous pop.
- Only one read is outstanding at a time. Later commands wait in the FIFO.

## Timing
- Command accepted at edge k with IDLE and the FIFO empty:
  - `csr_stb_o`/`csr_in_progress` high from edge k+1 to edge k+2.
  - Read data sampled at edge k+1+`READ_LATENCY`.
  - `rsp_valid` rises at that same edge.
- Next ACCESS after a read starts, at the earliest, one edge after the rsp handshake.
- `rst` asserted in any state, including mid-ACCESS or RESP with `rsp_valid` high:
  - Next edge: all outputs 0, FIFO empty, pending commands discarded, INIT restarts.
  - An in-flight strobe is truncated.

## Configuration
- `CSR_CMD_MASTER_WR_ECHO_EN`
  - Defined: writes also wait `READ_LATENCY` and return a response carrying the register readback (`rsp_err` as for reads). Back-to-back writes are then limited by the response handshake.
  - Undefined: writes produce no response, as described above.

## Test plan
- Reset release with `CSR_RESET_DELAY`=4 → `ready` and `cmd_ready` 0 for exactly 4 edges, then 1; all outputs 0 before that.
- Write sel=3, data=0xDEADBEEF → `csr_stb_o`=0x8 for exactly one cycle with `csr_data_o`=0xDEADBEEF and `csr_rw`=1; no `rsp_valid` (macro undefined).
- `READ_LATENCY`=3, register 5 driven to 0x12345678 → `rsp_valid` at edge k+4 with `rsp_data`=0x12345678, `rsp_sel`=5, `rsp_err`=0; response held while `rsp_ready`=0 for 5 cycles.
- 4 writes pushed with FIFO depth 4 and `rsp_ready`=0 → `cmd_ready` drops only when full; strobes 1,2,4,8 on consecutive cycles.
- `CSR_STROBE_BUS_WIDTH`=20, read sel=25 → `rsp_err`=1, `rsp_data`=0, no strobe, `err_count`=1; 300 such commands → `err_count`=255.
- `rst` pulsed during RESP with 2 commands queued → next edge `rsp_valid`=0, FIFO empty, `ready`=0; no stale access after `ready` returns.
